// File: rtl/wmem_burst.sv
// Weights memory for the PE array: row store, bias register and burst reader.
// One burst command streams consecutive rows, one per non-stalled cycle.
module wmem_burst #(
    parameter int DATA_WIDTH    = 8,
    parameter int ROW_NUM       = 6,
    parameter int ADDR_WIDTH    = 7,
    parameter int LEN_WIDTH     = ADDR_WIDTH + 1,
    parameter int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [ADDR_WIDTH-1:0]    i_wr_addr,
    input  logic [ROW_WGT_WIDTH-1:0] i_wr_data,
    input  logic                     i_bias_wr_en,
    input  logic [ROW_WGT_WIDTH-1:0] i_bias_data,
    input  logic                     i_burst_start,
    input  logic [ADDR_WIDTH-1:0]    i_burst_base,
    input  logic [LEN_WIDTH-1:0]     i_burst_len,
    input  logic                     i_stall,
    output logic                     o_busy,
    output logic                     o_rd_valid,
    output logic [ROW_WGT_WIDTH-1:0] o_rd_data,
    output logic                     o_rd_last,
    output logic [ROW_WGT_WIDTH-1:0] o_bias
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [ROW_WGT_WIDTH-1:0] mem [DEPTH];
    logic [0:0]               state;
    logic [ADDR_WIDTH-1:0]    ptr;
    logic [LEN_WIDTH-1:0]     cnt;

    assign o_busy = (state == RUN);

    // Row array write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Bias register, written independently of the burst engine.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_bias <= '0;
        end else if (i_bias_wr_en) begin
            o_bias <= i_bias_data;
        end
    end

    // Burst FSM and registered read stream; array read is read-first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            o_rd_valid <= 1'b0;
            o_rd_last  <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!i_stall) begin
                        o_rd_valid <= 1'b0;
                        o_rd_last  <= 1'b0;
                    end
                    if (i_burst_start && (i_burst_len != '0)) begin
                        state <= RUN;
                        ptr   <= i_burst_base;
                        cnt   <= i_burst_len;
                    end
                end
                RUN: begin
                    if (!i_stall) begin
                        o_rd_data  <= mem[ptr];
                        o_rd_valid <= 1'b1;
                        o_rd_last  <= (cnt == LEN_WIDTH'(1));
                        ptr        <= ptr + ADDR_WIDTH'(1);
                        cnt        <= cnt - LEN_WIDTH'(1);
                        if (cnt == LEN_WIDTH'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
